// File: rtl/serial_port_pkg.sv
// Shared constants for the serial port timing blocks.
package serial_port_pkg;

  // Default divisor field widths.
  localparam int DIV_W_DEFAULT  = 16;
  localparam int FRAC_W_DEFAULT = 4;

  // Smallest usable quarter-bit length; keeps `change` from firing on back-to-back cycles.
  localparam int MIN_DIV = 2;

  // Quarter-bit indices: PH_START opens a bit, PH_LAST closes it.
  localparam logic [1:0] PH_START = 2'd0;
  localparam logic [1:0] PH_LAST  = 2'd3;

endpackage

// File: rtl/serial_port_baud_gen.sv
// Baud-phase generator: paces TX/RX at four phases per bit with an
// integer-plus-fraction quarter-bit divisor. A new divisor is only applied
// at a bit boundary (or at once while disabled), so a bit never mixes timings.
//
// state    | meaning
// DISABLED | en=0: phase held at 3, counter and accumulator parked at 0
// Q0       | phase=0, first quarter of a bit (bit edge when change=1)
// Q1       | phase=1
// Q2       | phase=2
// Q3       | phase=3, last quarter; its expiry is the bit boundary
// The state lives in `phase` plus `en`; there is no separate state register.
module serial_port_baud_gen
  import serial_port_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEFAULT,
  parameter int FRAC_W      = FRAC_W_DEFAULT,
  parameter int DEFAULT_DIV = 217
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic [1:0]        phase,
  output logic              change,
  output logic              div_ack
);

  logic [DIV_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;
  logic [DIV_W-1:0]  pend_int;
  logic [FRAC_W-1:0] pend_frac;
  logic              pend_v;
  logic [DIV_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;

  logic              expiry;
  logic              boundary;
  logic              apply_bnd;
  logic              apply_dis;
  logic [DIV_W-1:0]  new_int;
  logic [FRAC_W-1:0] new_frac;
  logic [FRAC_W:0]   acc_sum;
  logic [DIV_W-1:0]  cnt_run;
  logic [DIV_W-1:0]  cnt_new;

  // Divisors 0 and 1 would give zero/one-cycle quarters; force them up.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : d;
  endfunction

  // Decode expiry and boundary events and the reload value for each case.
  always_comb begin
    expiry    = en && (cnt == '0);
    boundary  = expiry && (phase == PH_LAST);
    // A load landing on the boundary itself beats any older pending value.
    apply_bnd = boundary && (div_load || pend_v);
    apply_dis = !en && div_load;
    new_int   = div_load ? div_int  : pend_int;
    new_frac  = div_load ? div_frac : pend_frac;
    acc_sum   = {1'b0, acc} + {1'b0, act_frac};
    // The fraction carry stretches this quarter by one clock.
    cnt_run   = clamp_div(act_int) - DIV_W'(1)
              + {{(DIV_W-1){1'b0}}, acc_sum[FRAC_W]};
    // Fresh divisor starts with a cleared accumulator, so no carry yet.
    cnt_new   = clamp_div(new_int) - DIV_W'(1);
  end

  // Active divisor: replaced immediately while disabled, otherwise only at a boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_int  <= DIV_W'(DEFAULT_DIV);
      act_frac <= '0;
    end else if (apply_dis || apply_bnd) begin
      act_int  <= new_int;
      act_frac <= new_frac;
    end
  end

  // Pending divisor: holds a mid-bit load until the boundary; last load wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v    <= 1'b0;
      pend_int  <= '0;
      pend_frac <= '0;
    end else if (apply_dis || apply_bnd) begin
      pend_v    <= 1'b0;
    end else if (en && div_load) begin
      pend_v    <= 1'b1;
      pend_int  <= div_int;
      pend_frac <= div_frac;
    end
  end

  // Quarter timer, fraction accumulator and phase/change outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      phase  <= PH_LAST;
      change <= 1'b0;
    end else if (!en) begin
      // Parking at phase 3 with cnt=0 makes the first enabled cycle a boundary.
      cnt    <= '0;
      acc    <= '0;
      phase  <= PH_LAST;
      change <= 1'b0;
    end else if (expiry) begin
      phase  <= phase + 2'd1;
      change <= 1'b1;
      if (apply_bnd) begin
        cnt <= cnt_new;
        acc <= '0;
      end else begin
        cnt <= cnt_run;
        acc <= acc_sum[FRAC_W-1:0];
      end
    end else begin
      cnt    <= cnt - DIV_W'(1);
      change <= 1'b0;
    end
  end

  // Acknowledge one cycle after a divisor takes effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_ack <= 1'b0;
    end else begin
      div_ack <= apply_dis || apply_bnd;
    end
  end

endmodule

// File: tb/tb_serial_port_baud_gen.sv
// Self-checking bench for serial_port_baud_gen. The reference model walks the
// change events directly: each quarter lasts max(div,2) clocks plus one when
// the running fraction sum crosses a multiple of 2^FRAC_W.
module tb_serial_port_baud_gen;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int FR     = 1 << FRAC_W;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic [1:0]        phase;
  logic              change;
  logic              div_ack;

  int checks = 0;
  int errors = 0;

  // Loads issued while enabled, edges relative to the first enabled edge.
  int ld_edge[$];
  int ld_int[$];
  int ld_frac[$];
  // Events encoded as edge*8+phase for change, edge*8+4 for div_ack.
  int exp_q[$];
  int obs_q[$];
  int consec;

  serial_port_baud_gen #(
    .DIV_W(DIV_W), .FRAC_W(FRAC_W), .DEFAULT_DIV(217)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div_int(div_int), .div_frac(div_frac),
    .div_load(div_load), .phase(phase), .change(change), .div_ack(div_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end in time");
    $fatal(1, "watchdog");
  end

  task automatic ld_clear();
    ld_edge.delete(); ld_int.delete(); ld_frac.delete();
  endtask

  task automatic ld_add(input int e, input int di, input int df);
    ld_edge.push_back(e); ld_int.push_back(di); ld_frac.push_back(df);
  endtask

  // Expected change/ack events from edge 0 (first enabled edge) up to last.
  task automatic model(input int a_int, input int a_frac, input int last);
    int t, ph, s, len, eff, pi, pf, li, ni, nf;
    bit pv, app;
    t = 0; ph = 3; s = 0; pv = 0; pi = 0; pf = 0; li = 0; ni = 0; nf = 0;
    exp_q.delete();
    while (t <= last) begin
      while (li < ld_edge.size() && ld_edge[li] < t) begin
        pv = 1; pi = ld_int[li]; pf = ld_frac[li]; li++;
      end
      ph = (ph + 1) % 4;
      app = 0;
      if (li < ld_edge.size() && ld_edge[li] == t) begin
        if (ph == 0) begin app = 1; ni = ld_int[li]; nf = ld_frac[li]; pv = 0; end
        else begin pv = 1; pi = ld_int[li]; pf = ld_frac[li]; end
        li++;
      end
      if (ph == 0 && !app && pv) begin app = 1; ni = pi; nf = pf; pv = 0; end
      if (app) begin a_int = ni; a_frac = nf; s = 0; end
      eff = (a_int < 2) ? 2 : a_int;
      exp_q.push_back(t * 8 + ph);
      if (app) begin
        exp_q.push_back(t * 8 + 4);
        len = eff;
      end else begin
        s += a_frac;
        len = eff + s / FR - (s - a_frac) / FR;
      end
      t += len;
    end
  endtask

  // Enable and run n edges, applying ld_* loads and recording events.
  task automatic run(input int n);
    bit prev;
    prev = 0; consec = 0;
    obs_q.delete();
    en = 1'b1;
    for (int i = 0; i < n; i++) begin
      div_load = 1'b0;
      for (int k = 0; k < ld_edge.size(); k++) begin
        if (ld_edge[k] == i) begin
          div_load = 1'b1;
          div_int  = DIV_W'(ld_int[k]);
          div_frac = FRAC_W'(ld_frac[k]);
        end
      end
      @(posedge clk);
      @(negedge clk);
      if (change === 1'b1) begin
        obs_q.push_back(i * 8 + int'(phase));
        if (prev) consec++;
      end
      if (div_ack === 1'b1) obs_q.push_back(i * 8 + 4);
      prev = (change === 1'b1);
    end
    div_load = 1'b0;
  endtask

  // Load a divisor while disabled; returns div_ack seen after the load edge.
  task automatic dis_load(input int di, input int df, output bit ack);
    en = 1'b0;
    div_load = 1'b1;
    div_int  = DIV_W'(di);
    div_frac = FRAC_W'(df);
    @(posedge clk);
    @(negedge clk);
    ack = div_ack;
    div_load = 1'b0;
  endtask

  task automatic stop_en();
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; div_load = 1'b0; div_int = '0; div_frac = '0;
    repeat (2) @(negedge clk);
    checks++; if (phase !== 2'd3)  begin errors++; $display("FAIL reset_phase got %0d exp 3", phase); end
    checks++; if (change !== 1'b0) begin errors++; $display("FAIL reset_change got %0b exp 0", change); end
    checks++; if (div_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %0b exp 0", div_ack); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (phase !== 2'd3 || change !== 1'b0)
      begin errors++; $display("FAIL idle_after_reset got phase %0d change %0b exp 3/0", phase, change); end
  endtask

  task automatic test_basic();
    bit ack;
    dis_load(4, 0, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL basic_load_ack got %0b exp 1", ack); end
    ld_clear();
    model(4, 0, 59);
    run(60);
    checks++; if (obs_q.size() != exp_q.size())
      begin errors++; $display("FAIL basic_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] != exp_q[i])
        begin errors++; $display("FAIL basic_event[%0d] got %0d exp %0d", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (obs_q.size() > 1 && obs_q[1] != 4 * 8 + 1)
      begin errors++; $display("FAIL basic_second_change got %0d exp %0d", obs_q[1], 33); end
    stop_en();
  endtask

  task automatic test_frac();
    bit ack;
    dis_load(4, 8, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL frac_load_ack got %0b exp 1", ack); end
    ld_clear();
    model(4, 8, 79);
    run(80);
    checks++; if (obs_q.size() != exp_q.size())
      begin errors++; $display("FAIL frac_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] != exp_q[i])
        begin errors++; $display("FAIL frac_event[%0d] got %0d exp %0d", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (obs_q.size() <= 16 || obs_q[16] != 72 * 8)
      begin errors++; $display("FAIL frac_16_quarters got %0d exp %0d", (obs_q.size() > 16) ? obs_q[16] : -1, 72 * 8); end
    stop_en();
  endtask

  task automatic test_deferred();
    bit ack;
    dis_load(4, 0, ack);
    ld_clear();
    ld_add(5, 6, 0);
    ld_add(23, 7, 0);
    ld_add(30, 8, 0);
    model(4, 0, 69);
    run(70);
    checks++; if (obs_q.size() != exp_q.size())
      begin errors++; $display("FAIL deferred_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] != exp_q[i])
        begin errors++; $display("FAIL deferred_event[%0d] got %0d exp %0d", i, obs_q[i], exp_q[i]); end
    end
    // Acks only at the two boundaries (edges 16 and 40).
    begin
      int nack;
      nack = 0;
      foreach (obs_q[i]) if (obs_q[i] % 8 == 4) nack++;
      checks++; if (nack != 2) begin errors++; $display("FAIL deferred_ack_count got %0d exp 2", nack); end
    end
    stop_en();
  endtask

  task automatic test_min_div();
    bit ack;
    for (int d = 0; d < 2; d++) begin
      dis_load(d, 0, ack);
      ld_clear();
      model(d, 0, 29);
      run(30);
      checks++; if (obs_q.size() != exp_q.size())
        begin errors++; $display("FAIL min_div%0d_count got %0d exp %0d", d, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++; if (obs_q[i] != exp_q[i])
          begin errors++; $display("FAIL min_div%0d_event[%0d] got %0d exp %0d", d, i, obs_q[i], exp_q[i]); end
      end
      checks++; if (consec != 0) begin errors++; $display("FAIL min_div%0d_consecutive got %0d exp 0", d, consec); end
      stop_en();
    end
  endtask

  task automatic test_coincident();
    bit ack;
    dis_load(4, 0, ack);
    ld_clear();
    ld_add(5, 6, 0);
    ld_add(16, 9, 0);
    model(4, 0, 59);
    run(60);
    checks++; if (obs_q.size() != exp_q.size())
      begin errors++; $display("FAIL coincident_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] != exp_q[i])
        begin errors++; $display("FAIL coincident_event[%0d] got %0d exp %0d", i, obs_q[i], exp_q[i]); end
    end
    stop_en();
  endtask

  task automatic test_async_reset();
    bit ack;
    dis_load(3, 0, ack);
    ld_clear();
    ld_add(4, 5, 0);
    run(7);
    checks++; if (change !== 1'b1 || phase !== 2'd2)
      begin errors++; $display("FAIL prereset_state got phase %0d change %0b exp 2/1", phase, change); end
    #2;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    checks++; if (phase !== 2'd3)   begin errors++; $display("FAIL async_phase got %0d exp 3", phase); end
    checks++; if (change !== 1'b0)  begin errors++; $display("FAIL async_change got %0b exp 0", change); end
    checks++; if (div_ack !== 1'b0) begin errors++; $display("FAIL async_ack got %0b exp 0", div_ack); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ld_clear();
    model(217, 0, 449);
    run(450);
    checks++; if (obs_q.size() != exp_q.size())
      begin errors++; $display("FAIL post_reset_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] != exp_q[i])
        begin errors++; $display("FAIL post_reset_event[%0d] got %0d exp %0d", i, obs_q[i], exp_q[i]); end
    end
    stop_en();
  endtask

  task automatic test_random();
    bit ack;
    int di, df, nld, e, n;
    for (int it = 0; it < 8; it++) begin
      di = $urandom_range(0, 9);
      df = $urandom_range(0, FR - 1);
      dis_load(di, df, ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rand%0d_load_ack got %0b exp 1", it, ack); end
      ld_clear();
      n = 150;
      nld = $urandom_range(1, 3);
      e = 0;
      for (int k = 0; k < nld; k++) begin
        e = e + $urandom_range(3, 40);
        if (e < n - 10) ld_add(e, $urandom_range(0, 9), $urandom_range(0, FR - 1));
      end
      model(di, df, n - 1);
      run(n);
      checks++; if (obs_q.size() != exp_q.size())
        begin errors++; $display("FAIL rand%0d_count got %0d exp %0d", it, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++; if (obs_q[i] != exp_q[i])
          begin errors++; $display("FAIL rand%0d_event[%0d] got %0d exp %0d", it, i, obs_q[i], exp_q[i]); end
      end
      checks++; if (consec != 0) begin errors++; $display("FAIL rand%0d_consecutive got %0d exp 0", it, consec); end
      stop_en();
      checks++; if (phase !== 2'd3 || change !== 1'b0)
        begin errors++; $display("FAIL rand%0d_disable got phase %0d change %0b exp 3/0", it, phase, change); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frac();
    test_deferred();
    test_min_div();
    test_coincident();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_port_baud_gen.md
# serial_port_baud_gen

Baud-phase generator for the serial port. It produces the `phase`/`change` timing pair that paces the transmit handler (and the receive sampler) at four phases per bit. The quarter-bit period is programmable with an integer-plus-fraction divisor. Divisor updates are deferred to bit boundaries, so no bit is ever emitted with mixed timing.

## Interface
Parameters:
- `DIV_W`, 16, width of integer quarter-bit divisor
- `FRAC_W`, 4, width of fractional divisor (units of 1/2^FRAC_W clock)
- `DEFAULT_DIV`, 217, integer divisor after reset (100 MHz, 115200 baud); fraction resets to 0

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `en`  in  1  generator enable
- `div_int`  in  DIV_W  integer quarter-bit divisor, in clocks
- `div_frac`  in  FRAC_W  fractional quarter-bit divisor
- `div_load`  in  1  single-cycle strobe: capture `div_int`/`div_frac`
- `phase`  out  2  current quarter-bit index, 0..3; 0 = bit start
- `change`  out  1  one-cycle strobe, high in the first cycle of each new `phase` value
- `div_ack`  out  1  one-cycle strobe, high in the cycle after the new divisor takes effect

## Operation
- State: active divisor (int+frac), pending divisor plus `pend_v` flag, down-counter `cnt`, fraction accumulator `acc` (FRAC_W bits), `phase`, `change`, `div_ack`.
- Effective divisor is `max(div_int_active, 2)`. Values 0 and 1 clamp to 2.
- **Expiry**: `en`=1 and `cnt`=0. On expiry:
  - `phase` <= `phase`+1 (wraps 3 to 0), and `change` <= 1.
  - {carry, `acc`} <= `acc` + `frac_active`.
  - `cnt` <= eff_div − 1 + carry.
- A quarter therefore lasts eff_div or eff_div+1 clocks. Mean quarter length is div_int + div_frac/2^FRAC_W.
- **Bit boundary**: an expiry with `phase`=3. Divisor application happens only here.
  - If `div_load`=1 in the boundary cycle, the new input values apply directly at this boundary.
  - Otherwise, if `pend_v`=1, the pending values apply.
  - When applied, `acc` clears, `cnt` is reloaded from the new divisor, `pend_v` clears, and `div_ack` pulses next cycle.
- `div_load` outside a boundary, with `en`=1: the values are captured into pending and `pend_v` is set. Repeated loads before the boundary: last wins, one `div_ack`.
- **Disabled** (`en`=0):
  - `phase` held at 3, `cnt` held at 0, `acc` held at 0, `change`=0.
  - `div_load` applies immediately, and `div_ack` pulses next cycle.
  - The first enabled cycle is an expiry. Next cycle: `phase`=0, `change`=1, so the first bit starts one clock after `en` rises.
- `en` falling mid-bit: the generator returns to the disabled state next edge, and the partial bit is abandoned.
- States, in cycle order: DISABLED, then Q0, Q1, Q2, Q3, then back to Q0, encoded directly by `phase` and `en`. There is no separate FSM register.

## Timing
- Reset (asynchronous, immediate): `phase`=3, `change`=0, `div_ack`=0, `cnt`=0, `acc`=0, `pend_v`=0, active divisor=`DEFAULT_DIV`/0.
- Reset deasserted mid-count: the generator restarts as disabled. No pending update survives.
- `change` is registered and never high on two consecutive cycles, because the effective divisor is at least 2.
- The downstream bit edge is the cycle with `phase`==0 and `change`==1, exactly once per bit.
- All outputs are registered. Inputs have no combinational path to outputs.
- `div_ack` latency: one clock after application (boundary edge, or load edge when disabled).

## Structure
- Shared package `serial_port_pkg`:
  - `DIV_W`, `FRAC_W` defaults
  - `MIN_DIV`=2
  - phase constants `PH_START`=0, `PH_LAST`=3
- Single flat module, no sub-module. The fraction accumulator stays inline.
- Instantiated beside the transmit handler. `phase`/`change` fan out to the TX and RX handlers.

## Test plan
- Reset with `en`=0: `phase`=3, `change`=0, `div_ack`=0. Assert `rst_n` low mid-count → outputs return to these values without waiting for a clock edge.
- `div_int`=4, `div_frac`=0, load while disabled, `en`=1 → `div_ack` one cycle after the load edge. `change` one clock after `en` rises with `phase`=0, then every 4 clocks with `phase` 1,2,3,0.
- `div_int`=4, `div_frac`=8 (FRAC_W=4) → quarter lengths alternate 4,5. 16 quarters = 72 clocks.
- Running at 4/0, load 6/0 during `phase`=1 → the current bit finishes at 4-clock quarters. `div_ack` follows the boundary, and the next bit uses 6-clock quarters. A second load of 8/0 before the boundary → 8 applies, single `div_ack`.
- `div_int`=0 and `div_int`=1 → quarters of 2 clocks, and `change` is never high on consecutive cycles.
- `div_load` coincident with a boundary carrying an older pending value → the coincident value applies at that boundary and the older value is discarded.
